// File: rtl/sr_latch_trio.sv
// Three clocked set/reset cells (A: 1S/1R, B: 2S/2R, C: 2S/1R) modelled on cross-coupled NOR latches.
// Optional sticky illegal (S=R=1) flags are built only when SR_ILLEGAL_DET_EN is defined.

module SrCell #(
  parameter int   NUM_SET = 1,
  parameter int   NUM_RST = 1,
  parameter logic RESET_Q = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SET-1:0] i_set,
  input  logic [NUM_RST-1:0] i_clr,
  output logic               o_q,
  output logic               o_qbar
`ifdef SR_ILLEGAL_DET_EN
  ,
  output logic               o_ill
`endif
);

  // ST_FORBID is the NOR-latch S=R=1 state where both outputs sit low.
  typedef enum logic [1:0] {
    ST_CLR    = 2'b00,
    ST_SET    = 2'b01,
    ST_FORBID = 2'b10
  } state_t;

  state_t r_state;
  state_t w_nextState;
  logic   r_q;
  logic   r_qbar;
  logic   w_anySet;
  logic   w_anyClr;

  assign w_anySet = |i_set;
  assign w_anyClr = |i_clr;

  // Leaving the forbidden state on a quiet sample resolves to cleared instead of racing.
  always_comb begin
    w_nextState = r_state;
    unique case ({w_anySet, w_anyClr})
      2'b10:   w_nextState = ST_SET;
      2'b01:   w_nextState = ST_CLR;
      2'b11:   w_nextState = ST_FORBID;
      default: begin
        if (r_state == ST_FORBID) begin
          w_nextState = ST_CLR;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET_Q ? ST_SET : ST_CLR;
      r_q     <= RESET_Q;
      r_qbar  <= ~RESET_Q;
    end else begin
      r_state <= w_nextState;
      r_q     <= (w_nextState == ST_SET);
      r_qbar  <= (w_nextState == ST_CLR);
    end
  end

  assign o_q    = r_q;
  assign o_qbar = r_qbar;

`ifdef SR_ILLEGAL_DET_EN
  logic r_ill;

  // Sticky until reset so a single forbidden sample is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ill <= 1'b0;
    end else if (w_anySet && w_anyClr) begin
      r_ill <= 1'b1;
    end
  end

  assign o_ill = r_ill;
`endif

endmodule

module sr_latch_trio #(
  parameter logic RESET_Q = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a_s,
  input  logic a_r,
  input  logic b_s0,
  input  logic b_s1,
  input  logic b_r0,
  input  logic b_r1,
  input  logic c_s0,
  input  logic c_s1,
  input  logic c_r0,
  output logic a_q,
  output logic a_qbar,
  output logic b_q,
  output logic b_qbar,
  output logic c_q,
  output logic c_qbar
`ifdef SR_ILLEGAL_DET_EN
  ,
  output logic a_ill,
  output logic b_ill,
  output logic c_ill
`endif
);

  logic [1:0] w_bSet;
  logic [1:0] w_bClr;
  logic [1:0] w_cSet;

  assign w_bSet = {b_s1, b_s0};
  assign w_bClr = {b_r1, b_r0};
  assign w_cSet = {c_s1, c_s0};

  SrCell #(.NUM_SET(1), .NUM_RST(1), .RESET_Q(RESET_Q)) u_cellA (
    .clk    (clk),
    .rst    (rst),
    .i_set  (a_s),
    .i_clr  (a_r),
    .o_q    (a_q),
    .o_qbar (a_qbar)
`ifdef SR_ILLEGAL_DET_EN
    ,
    .o_ill  (a_ill)
`endif
  );

  SrCell #(.NUM_SET(2), .NUM_RST(2), .RESET_Q(RESET_Q)) u_cellB (
    .clk    (clk),
    .rst    (rst),
    .i_set  (w_bSet),
    .i_clr  (w_bClr),
    .o_q    (b_q),
    .o_qbar (b_qbar)
`ifdef SR_ILLEGAL_DET_EN
    ,
    .o_ill  (b_ill)
`endif
  );

  SrCell #(.NUM_SET(2), .NUM_RST(1), .RESET_Q(RESET_Q)) u_cellC (
    .clk    (clk),
    .rst    (rst),
    .i_set  (w_cSet),
    .i_clr  (c_r0),
    .o_q    (c_q),
    .o_qbar (c_qbar)
`ifdef SR_ILLEGAL_DET_EN
    ,
    .o_ill  (c_ill)
`endif
  );

endmodule

// File: tb/tb_sr_latch_trio.sv
// Scoreboard bench for sr_latch_trio: a behavioural NOR-latch model pushes expected outputs per edge.
// Illegal-flag checks are active when SR_ILLEGAL_DET_EN is defined.

module tb_sr_latch_trio;

  logic clk;
  logic rst;
  logic a_s, a_r;
  logic b_s0, b_s1, b_r0, b_r1;
  logic c_s0, c_s1, c_r0;
  logic a_q, a_qbar, b_q, b_qbar, c_q, c_qbar;
  logic [2:0] illObs;

  int errorCount = 0;
  int checkCount = 0;

  // Expected vector layout: {a_q,a_qbar,b_q,b_qbar,c_q,c_qbar,a_ill,b_ill,c_ill}
  logic [8:0] sbQueue[$];

  logic mAq, mAqb, mAill;
  logic mBq, mBqb, mBill;
  logic mCq, mCqb, mCill;

  sr_latch_trio dut (
    .clk    (clk),
    .rst    (rst),
    .a_s    (a_s),
    .a_r    (a_r),
    .b_s0   (b_s0),
    .b_s1   (b_s1),
    .b_r0   (b_r0),
    .b_r1   (b_r1),
    .c_s0   (c_s0),
    .c_s1   (c_s1),
    .c_r0   (c_r0),
    .a_q    (a_q),
    .a_qbar (a_qbar),
    .b_q    (b_q),
    .b_qbar (b_qbar),
    .c_q    (c_q),
    .c_qbar (c_qbar)
`ifdef SR_ILLEGAL_DET_EN
    ,
    .a_ill  (illObs[2]),
    .b_ill  (illObs[1]),
    .c_ill  (illObs[0])
`endif
  );

`ifndef SR_ILLEGAL_DET_EN
  assign illObs = 3'b000;
`endif

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [8:0] actual, input logic [8:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b required %b", tag, actual, expected);
    end
  endtask

  // Reference NOR-latch behaviour written in terms of the outputs themselves.
  task automatic modelCell(input logic s, input logic r, input logic qIn, input logic qbIn,
                           input logic illIn, output logic qOut, output logic qbOut,
                           output logic illOut);
    illOut = illIn;
    if (rst) begin
      qOut = 1'b0; qbOut = 1'b1; illOut = 1'b0;
    end else if (s && r) begin
      qOut = 1'b0; qbOut = 1'b0;
`ifdef SR_ILLEGAL_DET_EN
      illOut = 1'b1;
`endif
    end else if (s) begin
      qOut = 1'b1; qbOut = 1'b0;
    end else if (r) begin
      qOut = 1'b0; qbOut = 1'b1;
    end else if (!qIn && !qbIn) begin
      qOut = 1'b0; qbOut = 1'b1;
    end else begin
      qOut = qIn; qbOut = qbIn;
    end
  endtask

  // Predict, push, clock once, then pop and compare one edge later.
  task automatic applyStimulus(input string tag);
    logic [8:0] expVec;
    logic [8:0] actVec;
    modelCell(a_s, a_r, mAq, mAqb, mAill, mAq, mAqb, mAill);
    modelCell(b_s0 | b_s1, b_r0 | b_r1, mBq, mBqb, mBill, mBq, mBqb, mBill);
    modelCell(c_s0 | c_s1, c_r0, mCq, mCqb, mCill, mCq, mCqb, mCill);
    sbQueue.push_back({mAq, mAqb, mBq, mBqb, mCq, mCqb, mAill, mBill, mCill});
    @(posedge clk);
    #1;
    actVec = {a_q, a_qbar, b_q, b_qbar, c_q, c_qbar, illObs};
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, actVec, 9'bx);
    end else begin
      expVec = sbQueue.pop_front();
      checkOutput(tag, actVec, expVec);
    end
  endtask

  task automatic driveAll(input logic s, input logic r);
    rst = 1'b0;
    a_s = s; b_s0 = s; b_s1 = s; c_s0 = s; c_s1 = s;
    a_r = r; b_r0 = r; b_r1 = r; c_r0 = r;
  endtask

  task automatic driveNone();
    driveAll(1'b0, 1'b0);
  endtask

  logic [1:0] seqTable [17];

  initial begin
    seqTable = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b01,
                 2'b10, 2'b01, 2'b11, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
    mAq = 1'b0; mAqb = 1'b0; mAill = 1'b0;
    mBq = 1'b0; mBqb = 1'b0; mBill = 1'b0;
    mCq = 1'b0; mCqb = 1'b0; mCill = 1'b0;

    // Reset with set inputs asserted, proving reset has priority.
    driveAll(1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus("reset");
    for (int i = 0; i < 3; i++) begin
      driveNone();
      applyStimulus($sformatf("postResetHold%0d", i));
    end

    driveAll(1'b1, 1'b0); applyStimulus("setAll");
    driveNone();          applyStimulus("holdSet");
    driveAll(1'b0, 1'b1); applyStimulus("resetAll");

    // Individual OR inputs on B and C.
    driveNone(); b_s1 = 1'b1; applyStimulus("bSetViaS1");
    driveNone(); c_s0 = 1'b1; applyStimulus("cSetViaS0");
    driveNone(); b_r1 = 1'b1; applyStimulus("bClrViaR1");
    driveNone(); c_s1 = 1'b1; a_s = 1'b1; applyStimulus("cSetViaS1");
    driveNone(); b_s0 = 1'b1; b_r1 = 1'b1; c_r0 = 1'b1; applyStimulus("mixedCells");

    // Forbidden then quiet, forbidden then set.
    driveAll(1'b1, 1'b1); applyStimulus("forbid1");
    driveNone();          applyStimulus("forbidExitQuiet");
    driveNone();          applyStimulus("forbidExitHold");
    driveAll(1'b1, 1'b1); applyStimulus("forbid2");
    driveAll(1'b1, 1'b0); applyStimulus("forbidExitSet");

    // Reset in the middle of a forbidden state.
    driveAll(1'b1, 1'b1); applyStimulus("forbid3");
    driveAll(1'b1, 1'b1); rst = 1'b1; applyStimulus("resetFromForbid");

    for (int i = 0; i < 17; i++) begin
      driveAll(seqTable[i][1], seqTable[i][0]);
      applyStimulus($sformatf("seq%0d", i));
    end
    driveNone(); applyStimulus("stickyAfterSeq");

    driveNone(); rst = 1'b1; applyStimulus("resetClearsIll");

    // Independent random inputs per cell, with occasional reset.
    for (int i = 0; i < 60; i++) begin
      rst  = ($urandom_range(0, 15) == 0);
      a_s  = 1'($urandom_range(0, 1)); a_r  = 1'($urandom_range(0, 1));
      b_s0 = 1'($urandom_range(0, 1)); b_s1 = 1'($urandom_range(0, 1));
      b_r0 = 1'($urandom_range(0, 1)); b_r1 = 1'($urandom_range(0, 1));
      c_s0 = 1'($urandom_range(0, 1)); c_s1 = 1'($urandom_range(0, 1));
      c_r0 = 1'($urandom_range(0, 1));
      applyStimulus($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
